uart_receiver: RTL and testbench
================================

# uart_receiver

Asynchronous serial receiver, the host-to-FPGA end of the link whose FPGA-to-host direction the generator drives. It samples the host's transmit line (board net UART_TXD) at 16x the baud rate, decodes 8N1 frames LSB-first and queues bytes in a small FIFO. A valid/ready handshake delivers them to the core logic in the `sys_clk` domain. Framing and overrun errors are flagged as single-cycle pulses.

## Interface
Parameters:
- `clock_freq`, 46000000: clock frequency in Hz.
- `baud`, 115200: line rate in bit/s.
- `fifo_depth_log2`, 2: log2 of FIFO entries. Used only when `UART_RX_FIFO_EN` is defined.

Ports:
- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial line; asynchronous to `clock`; idles high.
- `data` out 8: byte at the FIFO head; valid while `valid`=1.
- `valid` out 1: FIFO non-empty.
- `ready` in 1: consumer accepts `data` when `valid && ready`.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a received byte is dropped because the FIFO is full.

## Operation
- `rxd` passes through a 2-flop synchronizer, which is reset to 1.
- Tick divider: `DIV = (clock_freq + baud*8) / (baud*16)`, integer rounding. This gives 25 at the defaults. A one-cycle `tick` fires every DIV clocks.
- The divider restarts from 0 on the cycle the falling edge is detected in IDLE.
- The 4-bit tick counter `tcnt` counts ticks within the current bit.
- State machine:
  - IDLE: wait for the synced line = 0. Then clear `tcnt` and the divider, go to START.
  - START: at tick 8 (mid start bit), if the line = 1 it is a glitch and the machine returns to IDLE. Otherwise clear `tcnt`, clear the bit index and go to DATA.
  - DATA: every 16th tick, shift the line into bit[index], LSB first. After bit 7 go to STOP.
  - STOP: at the 16th tick (mid stop bit):
    - line = 1: push the byte and go to IDLE.
    - line = 0: pulse `frame_err`, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synced line = 1, then go to IDLE. A break condition produces exactly one error.
- Push/pop rules:
  - Pop on `valid && ready`.
  - Push and pop in the same cycle are both performed, including when the FIFO is full (the push is not an overrun).
  - Push while full without a pop: the byte is dropped, `overrun` pulses, and the FIFO contents are unchanged.
  - Pointers wrap modulo depth. A separate count register of `fifo_depth_log2+1` bits distinguishes full from empty.
- `data` is the registered head entry. It changes only on a pop, or on a push into an empty FIFO.

## Timing
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0. The state machine is in IDLE and the FIFO is empty.
- Reset asserted mid-frame aborts the frame immediately. Reception resumes at the next falling edge after release.
- Latency: `valid` rises 1 clock after the stop-bit sample. That is 9.5 bit times + 2 sync + 1 clocks after the `rxd` falling edge: 3803 clocks at the defaults (±1 tick of divider phase).
- Pop-to-next-data: the next head appears on `data` in the cycle after the pop. `valid` drops in the same cycle if the FIFO becomes empty.
- Back-to-back frames: a stop bit of 1 bit time followed immediately by the next start bit is received without loss.
- Minimum accepted start pulse: 8 ticks (200 clocks at the defaults). Anything shorter is ignored.

## Configuration
- `UART_RX_FIFO_EN` defined: FIFO of 2^`fifo_depth_log2` entries, as described above.
- Not defined: single holding register (depth 1), and `fifo_depth_log2` is ignored.
  - `valid` is set on push and cleared on pop.
  - Push while `valid`=1 and no same-cycle pop: the byte is dropped and `overrun` pulses.

## Test plan
All scenarios use the defaults: 46 MHz, 115200 baud, 400 clocks per bit.
- Frame 0x55 then 0xA3 back-to-back, `ready`=1: `valid` pulses twice, `data`=0x55 then 0xA3, no error pulses; first `valid` at 3803±25 clocks after the first edge.
- 100-clock low glitch on `rxd`, then idle: no `valid`, no `frame_err`; a following 0x3C frame is received correctly.
- Frame 0x7E with stop bit low, line then held low 4000 clocks: exactly one `frame_err` pulse, no `valid`; the next 0x11 frame after the line returns high is received.
- FIFO enabled, `ready`=0, bytes 0x01..0x05 sent: after the 5th stop bit `overrun` pulses once; raising `ready` yields 0x01, 0x02, 0x03, 0x04, then `valid`=0.
- FIFO full, `ready` pulsed high in the exact cycle the 5th byte (0x05) is pushed: no `overrun`; reads yield 0x01..0x05.
- `reset` asserted low during data bit 4 of a frame, released 10 clocks later: outputs return to reset values, no byte is queued, the next 0xC9 frame is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled 8N1 receiver feeding a valid/ready byte queue.
// Define UART_RX_FIFO_EN for a 2**fifo_depth_log2 FIFO, else a 1-entry holding register.
module uart_receiver #(
  parameter int clock_freq      = 46000000,
  parameter int baud            = 115200,
  parameter int fifo_depth_log2 = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = (clock_freq + baud * 8) / (baud * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic          s1_q, s2_q;
  logic          line;
  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic [3:0]    tcnt_q, tcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          push;
  logic          ferr_d;
  logic          ferr_q;
  logic          ovr_d;
  logic          ovr_q;
  logic          pop;
  logic          do_push;
  logic [7:0]    data_q, data_d;

  assign line = s2_q;
  assign tick = (div_q == DW'(DIV - 1));

  // Two-flop synchronizer; the line idles high so it resets to 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= rxd;
      s2_q <= s1_q;
    end
  end

  // Frame decoder state, tick divider and shift register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  // Next-state: mid-start check at tick 8, then one sample every 16 ticks.
  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    tcnt_d  = tick ? tcnt_q + 4'd1 : tcnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!line) begin
          state_d = START;
          tcnt_d  = '0;
          div_d   = '0;
        end
      end
      START: begin
        if (tick && tcnt_q == 4'd7) begin
          if (line) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            tcnt_d  = '0;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (tick && tcnt_q == 4'd15) begin
          sh_d[idx_q] = line;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && tcnt_q == 4'd15) begin
          push    = line;
          ferr_d  = !line;
          state_d = line ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 2 ** fifo_depth_log2;
  localparam int PW    = (fifo_depth_log2 > 0) ? fifo_depth_log2 : 1;
  localparam int CW    = fifo_depth_log2 + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q, wp_nx, rp_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full;

  // Queue control; data_q mirrors the head so it is a clean register output.
  always_comb begin
    wp_nx   = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
    rp_nx   = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    pop     = !empty && ready;
    do_push = push && (!full || pop);
    ovr_d   = push && full && !pop;
    cnt_d   = cnt_q;
    if (do_push && !pop) cnt_d = cnt_q + CW'(1);
    else if (pop && !do_push) cnt_d = cnt_q - CW'(1);
    data_d = data_q;
    if (pop) begin
      if (cnt_q > CW'(1)) data_d = mem_q[rp_nx];
      else if (do_push) data_d = sh_q;
    end else if (do_push && empty) begin
      data_d = sh_q;
    end
  end

  // Storage array; contents are only meaningful below the count.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wp_q] <= sh_q;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_nx;
      if (pop) rp_q <= rp_nx;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign valid = !empty;
`else
  localparam int unused_depth_log2 = fifo_depth_log2;

  logic valid_q, valid_d;

  // Single holding register; a pop frees it for a same-cycle push.
  always_comb begin
    pop     = valid_q && ready;
    do_push = push && (!valid_q || pop);
    ovr_d   = push && valid_q && !pop;
    valid_d = do_push ? 1'b1 : (pop ? 1'b0 : valid_q);
    data_d  = do_push ? sh_q : data_q;
  end

  // Holding register state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
`endif

  // Error pulses are registered to keep outputs glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign data      = data_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: frame-level bench for uart_receiver at 400 clocks/bit.
// Expected bytes go to a queue when sent and are matched against bytes taken.
module tb_uart_receiver;

  localparam int BIT = 400;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rxd   = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  uart_receiver #(
    .clock_freq(46000000),
    .baud(115200),
    .fifo_depth_log2(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rxd(rxd),
    .data(data),
    .valid(valid),
    .ready(ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs[256];
  int         obs_wr = 0;
  int         obs_rd = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;

  // Monitor: record every accepted byte and every error pulse.
  always @(negedge clock) begin
    if (valid && ready) begin
      obs[obs_wr[7:0]] = data;
      obs_wr++;
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic bitv(input logic v, input int n);
    #1 rxd = v;
    repeat (n) @(posedge clock);
  endtask

  task automatic frame(input logic [7:0] b, input logic stopb);
    bitv(1'b0, BIT);
    for (int i = 0; i < 8; i++) bitv(b[i], BIT);
    bitv(stopb, BIT);
  endtask

  task automatic setrdy(input logic v);
    #1 ready = v;
  endtask

  task automatic drain(input string nm);
    logic [7:0] e;
    while (obs_rd != obs_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: got unexpected byte 0x%0h, want none",
                 nm, obs[obs_rd[7:0]]);
      end else begin
        e = exp_q.pop_front();
        chk(nm, int'(obs[obs_rd[7:0]]), int'(e));
      end
      obs_rd++;
    end
    chk({nm, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stopb;
    int         ferr;
  } vec_t;

  initial begin
    #1200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tv[3];
    int         f0;
    int         o0;
    int         lat;
    int         t0;
    logic [7:0] rb;

    tv[0] = '{8'h00, 1'b1, 0};
    tv[1] = '{8'hFF, 1'b1, 0};
    tv[2] = '{8'h96, 1'b0, 1};

    repeat (5) @(posedge clock);
    #1;
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovr", int'(overrun), 0);
    reset = 1'b1;
    ready = 1'b1;
    repeat (50) @(posedge clock);

    // Back-to-back 0x55, 0xA3 with first-byte latency
    f0  = ferr_cnt;
    o0  = ovr_cnt;
    lat = -1;
    t0  = 0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    fork
      begin
        frame(8'h55, 1'b1);
        frame(8'hA3, 1'b1);
      end
      begin
        #1 t0 = cyc;
        for (int i = 0; i < 4500; i++) begin
          @(negedge clock);
          if (valid) begin
            lat = cyc - t0;
            break;
          end
        end
      end
    join
    checks++;
    if (lat < 3778 || lat > 3828) begin
      errors++;
      $display("FAIL latency: got %0d clocks, want 3803 +/- 25", lat);
    end
    drain("b2b");
    chk("b2b_ferr", ferr_cnt - f0, 0);
    chk("b2b_ovr", ovr_cnt - o0, 0);

    // Table of single frames, good and bad stop bits
    for (int i = 0; i < 3; i++) begin
      f0 = ferr_cnt;
      if (tv[i].stopb) exp_q.push_back(tv[i].b);
      frame(tv[i].b, tv[i].stopb);
      bitv(1'b1, BIT);
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, tv[i].ferr);
    end

    // Short glitch is ignored, following frame is good
    f0 = ferr_cnt;
    bitv(1'b0, 100);
    bitv(1'b1, 600);
    chk("glitch_valid", obs_wr - obs_rd, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'h3C);
    frame(8'h3C, 1'b1);
    bitv(1'b1, 100);
    drain("glitch_next");

    // Break: bad stop then long low gives one error
    f0 = ferr_cnt;
    frame(8'h7E, 1'b0);
    bitv(1'b0, 4000);
    bitv(1'b1, 400);
    chk("break_valid", obs_wr - obs_rd, 0);
    chk("break_ferr", ferr_cnt - f0, 1);
    exp_q.push_back(8'h11);
    frame(8'h11, 1'b1);
    bitv(1'b1, 100);
    drain("break_next");
    chk("break_ferr_after", ferr_cnt - f0, 1);

    // Fill the queue, then push and pop in the same cycle, then overrun
    setrdy(1'b0);
    o0 = ovr_cnt;
    for (int i = 1; i <= DEPTH; i++) begin
      exp_q.push_back(8'(i));
      frame(8'(i), 1'b1);
    end
    bitv(1'b1, BIT);
    exp_q.push_back(8'(DEPTH + 1));
    fork
      frame(8'(DEPTH + 1), 1'b1);
      begin
        #1;
        repeat (3802) @(posedge clock);
        #1 ready = 1'b1;
        @(posedge clock);
        #1 ready = 1'b0;
      end
    join
    chk("pushpop_ovr", ovr_cnt - o0, 0);
    frame(8'(DEPTH + 2), 1'b1);
    bitv(1'b1, 100);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    setrdy(1'b1);
    bitv(1'b1, 50);
    drain("fifo");
    #1;
    chk("fifo_empty", int'(valid), 0);

    // Reset during data bit 4 aborts the frame and clears the queue
    setrdy(1'b0);
    frame(8'h42, 1'b1);
    bitv(1'b1, 100);
    #1;
    chk("pre_rst_valid", int'(valid), 1);
    chk("pre_rst_data", int'(data), 8'h42);
    rb = 8'hB4;
    bitv(1'b0, BIT);
    for (int i = 0; i < 4; i++) bitv(rb[i], BIT);
    bitv(rb[4], 200);
    #1;
    reset = 1'b0;
    rxd   = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("mid_rst_data", int'(data), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_ovr", int'(overrun), 0);
    reset = 1'b1;
    bitv(1'b1, 800);
    #1;
    chk("post_rst_valid", int'(valid), 0);
    setrdy(1'b1);
    exp_q.push_back(8'hC9);
    frame(8'hC9, 1'b1);
    bitv(1'b1, 100);
    drain("rst_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
